// File: rtl/corr_pkt_arbiter.sv
// Round-robin arbiter that captures one correlator result packet at a time and
// serialises it onto a shared byte-wide FIFO push port behind a source header.
module corr_pkt_arbiter #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned PKT_BYTES = 5,
  parameter logic [3:0]  HDR_TAG   = 4'hA
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_cg,
  input  logic                         i_flush,
  input  logic [N_SRC-1:0]             i_req,
  input  logic [N_SRC*PKT_BYTES*8-1:0] i_pkt,
  output logic [N_SRC-1:0]             o_ack,
  output logic [7:0]                   o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic [$clog2(N_SRC)-1:0]     o_rrPtr
);

  localparam int unsigned PtrW = $clog2(N_SRC);
  localparam int unsigned IdxW = $clog2(PKT_BYTES + 1);
  localparam int unsigned PayW = PKT_BYTES * 8;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_q, rr_d;
  logic [PtrW-1:0]   win_q, win_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [PayW-1:0]   pay_q, pay_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;

  logic [PtrW-1:0]   pick;
  logic [PtrW-1:0]   cand;
  logic              found;
  logic              grant;

  // First pending source at or after the round-robin pointer, wrapping.
  always_comb begin
    pick  = rr_q;
    cand  = rr_q;
    found = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      cand = PtrW'((32'(rr_q) + i) % N_SRC);
      if (!found && i_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign grant = (state_q == StIdle) && i_cg && found && !i_flush && !i_rst;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      rr_q    <= '0;
      win_q   <= '0;
      idx_q   <= '0;
      pay_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      win_q   <= win_d;
      idx_q   <= idx_d;
      pay_q   <= pay_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    idx_d   = idx_q;
    pay_d   = pay_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (i_cg) begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            state_d = StSend;
            win_d   = pick;
            rr_d    = PtrW'((32'(pick) + 1) % N_SRC);
            pay_d   = i_pkt[32'(pick) * PayW +: PayW];
            idx_d   = '0;
            data_d  = {HDR_TAG, 4'(pick)};
            valid_d = 1'b1;
          end
        end
        StSend: begin
          if (i_flush) begin
            state_d = StIdle;
            valid_d = 1'b0;
            idx_d   = '0;
          end else if (i_ready) begin
            if (idx_q == IdxW'(PKT_BYTES)) begin
              state_d = StIdle;
              valid_d = 1'b0;
              idx_d   = '0;
            end else begin
              // Index k on the wire is payload byte k-1, so preload byte idx_q.
              data_d = pay_q[32'(idx_q) * 8 +: 8];
              idx_d  = idx_q + IdxW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    o_ack       = '0;
    o_ack[pick] = grant;
    o_data      = data_q;
    o_valid     = valid_q;
    o_busy      = (state_q == StSend);
    o_rrPtr     = rr_q;
  end

endmodule

// File: tb/tb_corr_pkt_arbiter.sv
// Directed bench for corr_pkt_arbiter: arbitration order, serialisation,
// backpressure, flush, async reset and clock-gate behaviour.
module tb_corr_pkt_arbiter;

  logic         clk;
  logic         rst;
  logic         cg;
  logic         flush;
  logic [3:0]   req;
  logic [159:0] pkt;
  logic [3:0]   ack;
  logic [7:0]   data;
  logic         valid;
  logic         ready;
  logic         busy;
  logic [1:0]   rrptr;

  int n_chk;
  int n_err;

  corr_pkt_arbiter #(
    .N_SRC    (4),
    .PKT_BYTES(5),
    .HDR_TAG  (4'hA)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_cg   (cg),
    .i_flush(flush),
    .i_req  (req),
    .i_pkt  (pkt),
    .o_ack  (ack),
    .o_data (data),
    .o_valid(valid),
    .i_ready(ready),
    .o_busy (busy),
    .o_rrPtr(rrptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source s payload byte k; source 2 yields 11,22,33,44,55.
  function automatic logic [7:0] exp_byte(int s, int k);
    return 8'((k + 1) * 17 + s - 2);
  endfunction

  int          order [5] = '{0, 1, 2, 3, 0};
  int          n_ack;
  int          last_c;
  int          got;
  int          c_last;
  logic        hdr_pend;
  logic [3:0]  hdr_src;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    cg    = 1'b1;
    flush = 1'b0;
    ready = 1'b1;
    req   = 4'b0100;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 5; k++)
        pkt[(s*5+k)*8 +: 8] = exp_byte(s, k);

    // Reset state, with a request held during reset.
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rr", 32'(rrptr), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Single packet from source 2.
    check("t1_ack", 32'(ack), 32'h4);
    tick();
    req = 4'b0000;
    check("t1_hdr", 32'(data), 32'hA2);
    check("t1_valid", 32'(valid), 32'h1);
    check("t1_rr", 32'(rrptr), 32'h3);
    check("t1_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t1_byte", 32'(data), 32'(exp_byte(2, k)));
      check("t1_bvalid", 32'(valid), 32'h1);
    end
    tick();
    check("t1_end_valid", 32'(valid), 32'h0);
    check("t1_end_busy", 32'(busy), 32'h0);

    // Round-robin with all sources requesting from pointer 0.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req = 4'b1111;
    #1;
    n_ack    = 0;
    last_c   = 0;
    hdr_pend = 1'b0;
    hdr_src  = 4'h0;
    for (int c = 0; c < 60 && n_ack < 5; c++) begin
      if (hdr_pend) begin
        check("t2_hdr", 32'(data), 32'({4'hA, hdr_src}));
        hdr_pend = 1'b0;
      end
      if (ack != 4'b0000) begin
        check("t2_ack", 32'(ack), 32'(4'b0001 << order[n_ack]));
        if (n_ack > 0) check("t2_gap", 32'(c - last_c), 32'd7);
        last_c   = c;
        hdr_pend = 1'b1;
        hdr_src  = 4'(order[n_ack]);
        n_ack++;
      end
      tick();
    end
    check("t2_nack", 32'(n_ack), 32'd5);
    if (hdr_pend) check("t2_hdr_last", 32'(data), 32'({4'hA, hdr_src}));
    req = 4'b0000;
    for (int i = 0; i < 20 && busy; i++) tick();
    check("t2_idle", 32'(busy), 32'h0);
    check("t2_rr", 32'(rrptr), 32'h1);

    // Backpressure for three cycles while payload byte 22 is presented.
    req = 4'b0100;
    #1;
    check("t3_ack", 32'(ack), 32'h4);
    tick();
    req    = 4'b0000;
    got    = 0;
    c_last = 0;
    for (int c = 1; c < 20 && got < 6; c++) begin
      ready = !(c >= 3 && c <= 5);
      #1;
      check("t3_valid", 32'(valid), 32'h1);
      if (ready) begin
        check("t3_byte", 32'(data), got == 0 ? 32'hA2 : 32'(exp_byte(2, got - 1)));
        got++;
      end else begin
        check("t3_hold", 32'(data), 32'h22);
      end
      c_last = c;
      tick();
    end
    ready = 1'b1;
    check("t3_count", 32'(got), 32'd6);
    check("t3_cycles", 32'(c_last), 32'd9);
    check("t3_end_valid", 32'(valid), 32'h0);
    check("t3_rr", 32'(rrptr), 32'h3);

    // Flush after header and first payload byte are accepted.
    req = 4'b0001;
    #1;
    check("t4_ack", 32'(ack), 32'h1);
    tick();
    req = 4'b0000;
    check("t4_hdr", 32'(data), 32'hA0);
    tick();
    check("t4_b0", 32'(data), 32'(exp_byte(0, 0)));
    tick();
    check("t4_b1", 32'(data), 32'(exp_byte(0, 1)));
    flush = 1'b1;
    tick();
    check("t4_fl_valid", 32'(valid), 32'h0);
    check("t4_fl_busy", 32'(busy), 32'h0);
    check("t4_fl_rr", 32'(rrptr), 32'h1);
    req = 4'b0100;
    #1;
    check("t4_idle_flush_ack", 32'(ack), 32'h0);
    flush = 1'b0;
    #1;
    check("t4_re_ack", 32'(ack), 32'h4);
    tick();
    req = 4'b0000;
    check("t4_re_hdr", 32'(data), 32'hA2);
    tick();
    check("t4_re_b0", 32'(data), 32'h11);
    check("t4_re_rr", 32'(rrptr), 32'h3);

    // Asynchronous reset between clock edges mid-packet.
    #2;
    rst = 1'b1;
    #1;
    check("t5_valid", 32'(valid), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_rr", 32'(rrptr), 32'h0);
    check("t5_data", 32'(data), 32'h0);
    rst = 1'b0;

    // Clock gate low holds off the ack, then holds an in-flight byte.
    cg  = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t6_cg_ack", 32'(ack), 32'h0);
      check("t6_cg_busy", 32'(busy), 32'h0);
      tick();
    end
    cg = 1'b1;
    #1;
    check("t6_ack", 32'(ack), 32'h1);
    tick();
    req = 4'b0000;
    check("t6_hdr", 32'(data), 32'hA0);
    check("t6_valid", 32'(valid), 32'h1);
    cg = 1'b0;
    tick();
    tick();
    check("t6_hold_data", 32'(data), 32'hA0);
    check("t6_hold_busy", 32'(busy), 32'h1);
    check("t6_hold_rr", 32'(rrptr), 32'h1);
    cg = 1'b1;
    tick();
    check("t6_b0", 32'(data), 32'(exp_byte(0, 0)));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
